// File: rtl/swap_sched.sv
// Round-robin scheduler for a shared three-step register-file swap datapath (T<-a, a<-b, b<-T).
// Optional macro SWAP_SCHED_B2B_EN: S3 also arbitrates so back-to-back swaps run every 3 cycles.
module swap_sched #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_a,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_b,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [1:0]                sel,
    output logic                      t_we,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_raddr,
    output logic [ADDR_W-1:0]         rf_waddr
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     own_q, own_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] b_q, b_d;

    logic              arb_en;
    logic              hit;
    logic [IW-1:0]     pick;
    logic              null_swap;

    // First requester at or after last+1, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        hit  = 1'b0;
        pick = '0;
        idx  = 0;
        cand = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx  = (int'(last_q) + i) % N_REQ;
            cand = IW'(idx);
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
`ifdef SWAP_SCHED_B2B_EN
        arb_en = !reset && (state_q == IDLE || state_q == S3);
`else
        arb_en = !reset && (state_q == IDLE);
`endif
    end

    assign null_swap = (a_q == b_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        own_d    = own_q;
        a_d      = a_q;
        b_d      = b_q;
        gnt      = '0;
        done     = '0;
        busy     = (state_q != IDLE);
        sel      = state_q;
        t_we     = 1'b0;
        rf_we    = 1'b0;
        rf_raddr = '0;
        rf_waddr = '0;

        case (state_q)
            IDLE: state_d = IDLE;
            S1: begin
                rf_raddr = a_q;
                t_we     = !null_swap;
                state_d  = S2;
            end
            S2: begin
                rf_raddr = b_q;
                rf_waddr = a_q;
                rf_we    = !null_swap;
                state_d  = S3;
            end
            S3: begin
                rf_waddr    = b_q;
                rf_we       = !null_swap;
                done[own_q] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A grant overrides the return to IDLE (only reachable from S3 with B2B).
        if (arb_en && hit) begin
            gnt[pick] = 1'b1;
            last_d    = pick;
            own_d     = pick;
            a_d       = req_addr_a[int'(pick)*ADDR_W +: ADDR_W];
            b_d       = req_addr_b[int'(pick)*ADDR_W +: ADDR_W];
            state_d   = S1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(N_REQ - 1);
            own_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule

// File: tb/tb_swap_sched.sv
// Bench for swap_sched: timeline scoreboard of expected swap steps plus a register-file model.
// Build with +define+SWAP_SCHED_B2B_EN to exercise the back-to-back variant.
module tb_swap_sched;
    localparam int N  = 4;
    localparam int AW = 3;
`ifdef SWAP_SCHED_B2B_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr_a, addr_b;
    logic [N-1:0]  gnt, done;
    logic          busy, t_we, rf_we;
    logic [1:0]    sel;
    logic [AW-1:0] rf_raddr, rf_waddr;

    swap_sched #(.N_REQ(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_addr_a(addr_a), .req_addr_b(addr_b),
        .gnt(gnt), .done(done), .busy(busy), .sel(sel),
        .t_we(t_we), .rf_we(rf_we), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    int cyc = 0;

    logic [7:0] rf [8];
    logic [7:0] exp_rf [8];
    logic [7:0] t_m;

    // Expected outputs per future cycle, indexed by cycle mod 8.
    logic [1:0]    e_sel  [8];
    logic [AW-1:0] e_ra   [8];
    logic [AW-1:0] e_wa   [8];
    logic          e_twe  [8];
    logic          e_rfwe [8];
    logic [N-1:0]  e_done [8];
    int last_m;
    int free_at;
    int g_own[$];
    int g_cyc[$];

    task automatic check(string name, int act, int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_slot(int s);
        e_sel[s] = 0; e_ra[s] = 0; e_wa[s] = 0;
        e_twe[s] = 0; e_rfwe[s] = 0; e_done[s] = 0;
    endtask

    task automatic sched(int c, int own, logic [AW-1:0] a, logic [AW-1:0] b);
        logic w;
        int s1, s2, s3;
        w = (a != b);
        s1 = (c + 1) % 8; s2 = (c + 2) % 8; s3 = (c + 3) % 8;
        clear_slot(s1); clear_slot(s2); clear_slot(s3);
        e_sel[s1] = 1; e_ra[s1] = a; e_twe[s1] = w;
        e_sel[s2] = 2; e_ra[s2] = b; e_wa[s2] = a; e_rfwe[s2] = w;
        e_sel[s3] = 3; e_wa[s3] = b; e_rfwe[s3] = w;
        e_done[s3] = N'(1) << own;
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Register-file model driven by the DUT's selects and enables.
    always @(posedge clk) begin
        logic [7:0] wd;
        wd = (sel == 2'd3) ? t_m : rf[rf_raddr];
        if (t_we) t_m = rf[rf_raddr];
        if (rf_we) rf[rf_waddr] = wd;
    end

    // Scoreboard: grant rule, step timeline and expected register-file image.
    always @(negedge clk) begin
        int s, p;
        logic [N-1:0] eg;
        logic [7:0] tmp;
        logic [AW-1:0] a, b;
        s = cyc % 8;
        eg = '0;
        p = -1;
        if (reset !== 1'b1 && cyc >= free_at && req != 0) begin
            for (int k = 1; k <= N; k++)
                if (p < 0 && req[(last_m + k) % N]) p = (last_m + k) % N;
            eg[p] = 1'b1;
            last_m = p;
            free_at = cyc + GAP;
            a = addr_a[p*AW +: AW];
            b = addr_b[p*AW +: AW];
            sched(cyc, p, a, b);
            tmp = exp_rf[a]; exp_rf[a] = exp_rf[b]; exp_rf[b] = tmp;
        end
        for (int k = 0; k < N; k++)
            if (gnt[k]) begin g_own.push_back(k); g_cyc.push_back(cyc); end
        check("gnt", int'(gnt), int'(eg));
        check("busy", int'(busy), int'(e_sel[s] != 0));
        check("sel", int'(sel), int'(e_sel[s]));
        check("rf_raddr", int'(rf_raddr), int'(e_ra[s]));
        check("rf_waddr", int'(rf_waddr), int'(e_wa[s]));
        check("t_we", int'(t_we), int'(e_twe[s]));
        check("rf_we", int'(rf_we), int'(e_rfwe[s]));
        check("done", int'(done), int'(e_done[s]));
        clear_slot(s);
        if (reset === 1'b1) begin
            for (int k = 0; k < 8; k++) clear_slot(k);
            last_m = N - 1;
            free_at = cyc + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setaddr(int i, int a, int b);
        addr_a[i*AW +: AW] = AW'(a);
        addr_b[i*AW +: AW] = AW'(b);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic wait_idle(int max);
        int n;
        n = 0;
        while (busy && n < max) begin tick; n++; end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic check_rf;
        for (int i = 0; i < 8; i++) check("rf_image", int'(rf[i]), int'(exp_rf[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, wr, dn, g2;
        int ord [5];
        logic [7:0] saved;
        ord = '{0, 1, 2, 3, 0};
        last_m = N - 1;
        free_at = 0;
        t_m = 0;
        for (int k = 0; k < 8; k++) begin
            clear_slot(k);
            rf[k] = 8'(16 * k + 3);
            exp_rf[k] = rf[k];
        end
        reset = 1'b1; req = '0; addr_a = '0; addr_b = '0;
        tick; tick;
        @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_we", int'(t_we | rf_we), 0);
        check("rst_addr", int'(rf_raddr | rf_waddr), 0);
        check("rst_done", int'(done), 0);
        tick;
        reset = 1'b0;

        // Single request, a=2 b=5.
        setaddr(0, 2, 5); req = 4'b0001;
        @(negedge clk); check("t1_gnt", int'(gnt), 1);
        tick; req = 0;
        @(negedge clk);
        check("t1_s1_sel", int'(sel), 1); check("t1_s1_ra", int'(rf_raddr), 2);
        check("t1_s1_twe", int'(t_we), 1);
        tick; @(negedge clk);
        check("t1_s2_sel", int'(sel), 2); check("t1_s2_ra", int'(rf_raddr), 5);
        check("t1_s2_wa", int'(rf_waddr), 2); check("t1_s2_we", int'(rf_we), 1);
        tick; @(negedge clk);
        check("t1_s3_sel", int'(sel), 3); check("t1_s3_wa", int'(rf_waddr), 5);
        check("t1_s3_we", int'(rf_we), 1); check("t1_done", int'(done), 1);
        tick; @(negedge clk);
        check("t1_idle", int'(busy), 0);
        check("t1_rf2", int'(rf[2]), 8'h53);
        check("t1_rf5", int'(rf[5]), 8'h23);
        check_rf;

        // Continuous load from all four requesters.
        tick; do_reset;
        g_own.delete(); g_cyc.delete();
        for (int i = 0; i < N; i++) setaddr(i, i, i + 4);
        req = 4'hF;
        n = 0;
        while (g_own.size() < 5 && n < 60) begin tick; n++; end
        req = 0;
        check("t2_grants", g_own.size(), 5);
        if (g_own.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t2_order", g_own[k], ord[k]);
            for (int k = 1; k < 5; k++) check("t2_gap", g_cyc[k] - g_cyc[k-1], GAP);
        end
        wait_idle(10);
        tick;
        check_rf;

        // Null swap a=b=4.
        setaddr(1, 4, 4); req = 4'b0010;
        saved = rf[4];
        @(negedge clk); check("t3_gnt", int'(gnt), 2);
        tick; req = 0;
        wr = 0; dn = 0;
        repeat (3) begin
            @(negedge clk);
            wr = wr | int'(t_we | rf_we);
            if (done == 4'b0010) dn++;
            tick;
        end
        check("t3_no_we", wr, 0);
        check("t3_done", dn, 1);
        check("t3_rf4", int'(rf[4]), int'(saved));
        check_rf;

        // req[2] raised only while busy, dropped before idle.
        setaddr(0, 1, 3); req = 4'b0001;
        @(negedge clk); check("t4_gnt", int'(gnt), 1);
        g2 = 0;
        tick; req = 4'b0100;
        @(negedge clk); g2 += int'(gnt[2]);
        tick; req = 0;
        @(negedge clk); g2 += int'(gnt[2]);
        tick; @(negedge clk); g2 += int'(gnt[2]);
        tick; @(negedge clk); g2 += int'(gnt[2]);
        check("t4_no_gnt2", g2, 0);
        tick;
        check_rf;

        // Reset during S2 aborts the swap; requester 0 regains priority.
        setaddr(1, 6, 7); req = 4'b0010;
        @(negedge clk); check("t5_gnt", int'(gnt), 2);
        tick; req = 0;
        tick; reset = 1'b1;
        @(negedge clk); check("t5_in_s2", int'(sel), 2);
        tick; @(negedge clk);
        check("t5_busy", int'(busy), 0); check("t5_sel", int'(sel), 0);
        check("t5_we", int'(t_we | rf_we), 0); check("t5_done", int'(done), 0);
        check("t5_addr", int'(rf_raddr | rf_waddr), 0);
        tick; reset = 1'b0;
        for (int k = 0; k < 8; k++) exp_rf[k] = rf[k];
        req = 4'hF;
        @(negedge clk); check("t5_prio", int'(gnt), 1);
        tick; req = 0;
        wait_idle(10);
        tick;
        check_rf;

        // Latched addresses hold while inputs change.
        setaddr(3, 0, 6); req = 4'b1000;
        @(negedge clk); check("t6_gnt", int'(gnt), 8);
        tick; req = 0; setaddr(3, 7, 7);
        @(negedge clk); check("t6_s1_ra", int'(rf_raddr), 0);
        tick; setaddr(3, 1, 2);
        @(negedge clk);
        check("t6_s2_ra", int'(rf_raddr), 6); check("t6_s2_wa", int'(rf_waddr), 0);
        tick; setaddr(3, 5, 4);
        @(negedge clk); check("t6_s3_wa", int'(rf_waddr), 6);
        tick;
        wait_idle(10);
        tick;
        check_rf;

        tick; tick;
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule

// File: doc/swap_sched.md
# swap_sched

Round-robin scheduler that shares a single register-file swap datapath (temp register T plus a write-data mux) among `N_REQ` requesters. Each requester names two register addresses; the block grants one request at a time and sequences the three-step swap T←RF[a], RF[a]←RF[b], RF[b]←T. It sits between the requesting control logic and the register file, owning all datapath selects and write enables.

## Interface

Parameters:
- `N_REQ`, default 4, number of requesters (2..8).
- `ADDR_W`, default 3, register-file address width.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  `N_REQ`  per-requester swap request, level; held until `gnt`.
- `req_addr_a`  input  `N_REQ*ADDR_W`  packed address a; requester i uses bits `[i*ADDR_W +: ADDR_W]`.
- `req_addr_b`  input  `N_REQ*ADDR_W`  packed address b, same packing.
- `gnt`  output  `N_REQ`  one-hot, one-cycle pulse on acceptance.
- `done`  output  `N_REQ`  one-hot, one-cycle pulse in the final swap step.
- `busy`  output  1  high while a swap is in progress (state ≠ IDLE).
- `sel`  output  2  step code: 0 idle, 1 load T, 2 RF[a]←RF[b], 3 RF[b]←T (3 selects T as write data).
- `t_we`  output  1  temp register write enable.
- `rf_we`  output  1  register-file write enable.
- `rf_raddr`  output  `ADDR_W`  register-file read address.
- `rf_waddr`  output  `ADDR_W`  register-file write address.

## Operation

- States: IDLE, S1, S2, S3; `sel` equals state code (IDLE=0 … S3=3).
- IDLE: if any `req` is high, arbitrate, pulse `gnt[k]`, latch `req_addr_a/b[k]` and owner k, then go to S1. Otherwise stay in IDLE.
- Arbitration: round-robin. Search starts at `last+1` mod `N_REQ`, where `last` is the most recently granted index. `last` updates on each grant.
- S1: `rf_raddr`=a, `t_we`=1 → S2.
- S2: `rf_raddr`=b, `rf_waddr`=a, `rf_we`=1 → S3.
- S3: `rf_waddr`=b, `rf_we`=1, `done[owner]`=1 → IDLE.
- Null swap (a==b): same state sequence and latency, but `t_we` and `rf_we` are held 0. `done` still pulses.
- Requests are sampled only at arbitration. A `req` dropped before `gnt` is withdrawn; `req` changes after `gnt` are ignored until the next arbitration.
- Latched addresses are stable from S1 through S3 regardless of input changes.
- Address outputs are 0 when not used in the current state.

## Timing

- Reset (synchronous, active-high): state=IDLE, `last`=`N_REQ-1` (requester 0 has top priority), latched addresses=0, owner=0. All outputs are 0.
- `gnt` is combinational from `req` in IDLE, in the same cycle `req` is first sampled high while idle.
- The S1, S2 and S3 outputs decode from registered state and latched addresses, with no input-to-output paths.
- `done` is asserted 3 cycles after the `gnt` cycle.
- Default throughput: 4 cycles per swap (IDLE grant cycle + S1..S3).
- Reset asserted mid-swap aborts immediately at the next edge. No further writes occur, and no `done` is issued for the aborted request.

## Configuration

- `SWAP_SCHED_B2B_EN` defined: S3 also arbitrates.
  - If any `req` is high, S3 pulses `gnt`, latches the new request and goes directly to S1, in the same cycle as `done` for the old owner.
  - Throughput is 3 cycles per swap under continuous load.
  - A requester re-requesting immediately after its own `done` is subject to normal round-robin order.
- Undefined: S3 always returns to IDLE, and `gnt` is only produced in IDLE.

## Test plan

- Reset, then single request. `req`=0001, a=2, b=5 → `gnt`=0001 at cycle 0. Cycle 1: `sel`=1, `rf_raddr`=2, `t_we`=1. Cycle 2: `sel`=2, `rf_raddr`=5, `rf_waddr`=2, `rf_we`=1. Cycle 3: `sel`=3, `rf_waddr`=5, `rf_we`=1, `done`=0001. Register-file model shows RF[2] and RF[5] exchanged.
- All four requesting continuously → grant order 0,1,2,3,0. `gnt` spacing is 4 cycles (3 cycles with `SWAP_SCHED_B2B_EN`).
- Null swap: a=b=4 → full 3-step sequence with `t_we`=`rf_we`=0 throughout, `done` pulses, RF unchanged.
- Request withdrawal: `req[2]` is pulsed high only while busy and dropped before IDLE → no `gnt[2]`.
- Reset asserted in S2 → all outputs 0 next cycle. No `done`. The next request after reset is granted with requester 0 having priority.
- Address hold: change `req_addr_a/b` during S1..S3 → write addresses still equal the values latched at `gnt`.
